stage_ex_muldiv: RTL

//  Iterative multiply/divide unit beside the EX-stage ALU: MULT/MULTU/DIV/DIVU (+MADD/MSUB optional).
//  One bit per cycle, writing a {hi,lo} pair.
//  EX holds the pipeline while busy=1 and commits result_hi/lo on the done pulse.

---
 rtl/stage_ex_muldiv_pkg.sv | 38 +++
 rtl/muldiv_datapath.sv | 80 ++++++++
 rtl/stage_ex_muldiv.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/stage_ex_muldiv_pkg.sv
// Shared op codes, FSM state encodings and op-decode helpers for the iterative mul/div unit.
// The accumulate ops are only accepted when MULDIV_ACCUMULATE_EN is defined (see stage_ex_muldiv).
package stage_ex_muldiv_pkg;

  localparam logic [2:0] MULDIV_OP_MULT  = 3'd0;
  localparam logic [2:0] MULDIV_OP_MULTU = 3'd1;
  localparam logic [2:0] MULDIV_OP_DIV   = 3'd2;
  localparam logic [2:0] MULDIV_OP_DIVU  = 3'd3;
  localparam logic [2:0] MULDIV_OP_MADD  = 3'd4;
  localparam logic [2:0] MULDIV_OP_MADDU = 3'd5;
  localparam logic [2:0] MULDIV_OP_MSUB  = 3'd6;
  localparam logic [2:0] MULDIV_OP_MSUBU = 3'd7;

  typedef enum logic [1:0] {
    MULDIV_STATE_IDLE  = 2'd0,
    MULDIV_STATE_CALC  = 2'd1,
    MULDIV_STATE_ACCUM = 2'd2,
    MULDIV_STATE_DONE  = 2'd3
  } muldiv_state_t;

  // Odd codes are the unsigned variants.
  function automatic logic op_is_signed(input logic [2:0] op);
    return !op[0];
  endfunction

  function automatic logic op_is_div(input logic [2:0] op);
    return op[2:1] == 2'b01;
  endfunction

  function automatic logic op_is_acc(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic op_is_sub(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Datapath for the iterative mul/div: operand magnitude conversion, one shift-add or
// restoring-subtract step per cycle on a 2*WIDTH accumulator, and final sign fix-up.
module muldiv_datapath
  import stage_ex_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clock,
  input  logic               load,
  input  logic               step,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   operand_a,
  input  logic [WIDTH-1:0]   operand_b,
  output logic [2*WIDTH-1:0] result_step,
  output logic [2*WIDTH-1:0] result_now
);

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH-1:0]   mag;
  logic               is_div;
  logic               neg_q;
  logic               neg_r;

  logic               neg_a;
  logic               neg_b;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH:0]     diff;

  // Mult negates the whole product; div negates quotient and remainder separately.
  function automatic logic [2*WIDTH-1:0] sign_fix(input logic [2*WIDTH-1:0] x,
                                                  input logic div, input logic nq,
                                                  input logic nr);
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    if (!div) return nq ? -x : x;
    hi = x[2*WIDTH-1:WIDTH];
    lo = x[WIDTH-1:0];
    return {nr ? -hi : hi, nq ? -lo : lo};
  endfunction

  always_comb begin
    neg_a = op_is_signed(op) & operand_a[WIDTH-1];
    neg_b = op_is_signed(op) & operand_b[WIDTH-1];
    mag_a = neg_a ? -operand_a : operand_a;
    mag_b = neg_b ? -operand_b : operand_b;
  end

  // Mult: add multiplicand into the upper half on lsb=1, then shift right.
  // Div: shift the next dividend bit into the remainder, subtract if it fits.
  always_comb begin
    sum       = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag} : '0);
    rem_shift = acc[2*WIDTH-1:WIDTH-1];
    diff      = rem_shift - {1'b0, mag};
    if (is_div)
      acc_step = diff[WIDTH] ? {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                             : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    else
      acc_step = {sum, acc[WIDTH-1:1]};
  end

  always_ff @(posedge clock) begin
    if (load) begin
      is_div <= op_is_div(op);
      neg_q  <= neg_a ^ neg_b;
      neg_r  <= neg_a;
      mag    <= op_is_div(op) ? mag_b : mag_a;
      acc    <= {{WIDTH{1'b0}}, op_is_div(op) ? mag_a : mag_b};
    end else if (step) begin
      acc <= acc_step;
    end
  end

  assign result_step = sign_fix(acc_step, is_div, neg_q, neg_r);
  assign result_now  = sign_fix(acc, is_div, neg_q, neg_r);

endmodule

// File: rtl/stage_ex_muldiv.sv
// EX-stage iterative multiply/divide unit: FSM, bit counter, cancel and result registers.
// Define MULDIV_ACCUMULATE_EN to enable MADD/MADDU/MSUB/MSUBU through the ACCUM state.
module stage_ex_muldiv
  import stage_ex_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_hi,
  output logic [WIDTH-1:0] result_lo
);

  localparam int CW = $clog2(WIDTH);

  muldiv_state_t      state;
  muldiv_state_t      state_next;
  logic [CW-1:0]      counter;
  logic               op_ok;
  logic               div_zero;
  logic               load;
  logic               step;
  logic               res_load;
  logic               calc_to_accum;
  logic [2*WIDTH-1:0] res_value;
  logic [2*WIDTH-1:0] acc_value;
  logic [2*WIDTH-1:0] result_step;
  logic [2*WIDTH-1:0] result_now;

  muldiv_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clock       (clock),
    .load        (load),
    .step        (step),
    .op          (op),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .result_step (result_step),
    .result_now  (result_now)
  );

`ifdef MULDIV_ACCUMULATE_EN
  logic [2*WIDTH-1:0] hilo_l;
  logic               acc_l;
  logic               sub_l;

  always_ff @(posedge clock) begin
    if (load) begin
      hilo_l <= {hi_i, lo_i};
      acc_l  <= op_is_acc(op);
      sub_l  <= op_is_sub(op);
    end
  end

  assign op_ok         = 1'b1;
  assign calc_to_accum = acc_l;
  assign acc_value     = sub_l ? hilo_l - result_now : hilo_l + result_now;
`else
  logic unused_acc;

  assign op_ok         = !op_is_acc(op);
  assign calc_to_accum = 1'b0;
  assign acc_value     = result_now;
  assign unused_acc    = ^{hi_i, lo_i};
`endif

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    res_load   = 1'b0;
    res_value  = result_step;
    div_zero   = op_is_div(op) && (operand_b == '0);
    case (state)
      MULDIV_STATE_IDLE, MULDIV_STATE_DONE: begin
        state_next = MULDIV_STATE_IDLE;
        if (start && op_ok) begin
          load = 1'b1;
          if (div_zero) begin
            state_next = MULDIV_STATE_DONE;
            res_load   = 1'b1;
            res_value  = {operand_a, {WIDTH{1'b1}}};
          end else begin
            state_next = MULDIV_STATE_CALC;
          end
        end
      end
      MULDIV_STATE_CALC: begin
        step = 1'b1;
        if (counter == '0) begin
          if (calc_to_accum) begin
            state_next = MULDIV_STATE_ACCUM;
          end else begin
            state_next = MULDIV_STATE_DONE;
            res_load   = 1'b1;
          end
        end
      end
      MULDIV_STATE_ACCUM: begin
        state_next = MULDIV_STATE_DONE;
        res_load   = 1'b1;
        res_value  = acc_value;
      end
      default: state_next = MULDIV_STATE_IDLE;
    endcase
    // A flush wins over everything, including a same-cycle start.
    if (cancel) begin
      state_next = MULDIV_STATE_IDLE;
      load       = 1'b0;
      step       = 1'b0;
      res_load   = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= MULDIV_STATE_IDLE;
      counter   <= '0;
      result_hi <= '0;
      result_lo <= '0;
    end else begin
      state <= state_next;
      if (load)
        counter <= CW'(WIDTH - 1);
      else if (step && counter != '0)
        counter <= counter - CW'(1);
      if (res_load)
        {result_hi, result_lo} <= res_value;
    end
  end

  assign busy = (state == MULDIV_STATE_CALC) || (state == MULDIV_STATE_ACCUM);
  assign done = (state == MULDIV_STATE_DONE);

endmodule
